// File: rtl/n64_vbus_gen_pkg.sv
// n64_vbus_gen_pkg: N64 video bus geometry, colour width, word-slot encoding and sync-bit layout
// shared by the transmitter and the bus receivers.
package n64_vbus_gen_pkg;
   localparam int CW = 7;
   localparam int HW = 10;
   localparam int VW = 9;
   localparam int N64_H_TOTAL = 773;
   localparam int N64_H_SYNC = 57;
   localparam int N64_H_ACT_START = 108;
   localparam int N64_H_ACT = 640;
   localparam int N64_V_TOTAL = 263;
   localparam int N64_V_SYNC = 3;
   localparam int N64_V_ACT_START = 20;
   localparam int N64_V_ACT = 240;
   localparam int CLAMP_W = 16;
   localparam logic [1:0] W_SYNC = 2'd0;
   localparam logic [1:0] W_R = 2'd1;
   localparam logic [1:0] W_G = 2'd2;
   localparam logic [1:0] W_B = 2'd3;
   typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_BLACK} pat_e;
   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;
   function automatic logic [CW-1:0] sync_word(input logic nvs, input logic ncl, input logic nhs, input logic ncs);
      return {3'b000, nvs, ncl, nhs, ncs};
   endfunction
endpackage

// File: rtl/n64_vbus_gen_if.sv
// n64_vbus_gen_if: generator settings and the N64 digital video bus (nDSYNC + 7-bit words).
interface n64_vbus_gen_if;
   import n64_vbus_gen_pkg::*;
   logic n64_480i_i;
   logic [1:0] pattern_i;
   logic blur_i;
   logic nDSYNC;
   logic [CW-1:0] D_o;
   logic frame_start_o;
   logic field_o;
   modport master(input n64_480i_i, pattern_i, blur_i, output nDSYNC, D_o, frame_start_o, field_o);
   modport slave(output n64_480i_i, pattern_i, blur_i, input nDSYNC, D_o, frame_start_o, field_o);
endinterface

// File: rtl/n64_vbus_gen_pattern.sv
// n64_vbus_gen_pattern: test-pattern pixel generator; N64-style horizontal blur on odd pixels
// is built only when N64_VBUS_GEN_BLUR_EN is defined.
module n64_vbus_gen_pattern
   import n64_vbus_gen_pkg::*;
#(
   parameter int H_ACT = N64_H_ACT
) (
   input  logic [HW-1:0] x_i,
   input  logic          y0_i,
   input  logic          active_i,
   input  pat_e          pattern_i,
   input  logic          blur_i,
   output rgb_t          rgb_o
);
   function automatic rgb_t pix(input pat_e p, input logic [HW-1:0] x, input logic y0);
      logic [2:0] bar;
      logic [CW-1:0] chk;
      bar = 3'(x / HW'(H_ACT / 8));
      chk = {CW{x[0] ^ y0}};
      return p == PAT_BARS ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}}
           : p == PAT_RAMP ? {3{x[CW-1:0]}}
           : p == PAT_CHECK ? {3{chk}} : '0;
   endfunction
`ifdef N64_VBUS_GEN_BLUR_EN
   rgb_t raw, lft, rgt;
   function automatic logic [CW-1:0] avg(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, 1'b1};
      return CW'(s >> 1);
   endfunction
   assign raw = pix(pattern_i, x_i, y0_i);
   assign lft = pix(pattern_i, x_i - HW'(1), y0_i);
   // the last odd pixel has no right neighbour, so the left one counts twice
   assign rgt = x_i == HW'(H_ACT - 1) ? lft : pix(pattern_i, x_i + HW'(1), y0_i);
   assign rgb_o = !active_i ? '0
                : blur_i && x_i[0] ? {avg(lft.r, rgt.r), avg(lft.g, rgt.g), avg(lft.b, rgt.b)} : raw;
`else
   logic unused_blur;
   assign unused_blur = blur_i;
   assign rgb_o = active_i ? pix(pattern_i, x_i, y0_i) : '0;
`endif
endmodule

// File: rtl/n64_vbus_gen.sv
// n64_vbus_gen: N64 digital video bus transmitter emitting 240p/480i test-pattern frames.
// Optional blur is compiled in with N64_VBUS_GEN_BLUR_EN.
module n64_vbus_gen
   import n64_vbus_gen_pkg::*;
#(
   parameter int H_TOTAL = N64_H_TOTAL,
   parameter int H_SYNC = N64_H_SYNC,
   parameter int H_ACT_START = N64_H_ACT_START,
   parameter int H_ACT = N64_H_ACT,
   parameter int V_TOTAL = N64_V_TOTAL,
   parameter int V_SYNC = N64_V_SYNC,
   parameter int V_ACT_START = N64_V_ACT_START,
   parameter int V_ACT = N64_V_ACT
) (
   input logic VCLK,
   input logic RST,
   n64_vbus_gen_if.master bus
);
   logic [1:0] wcnt_q;
   logic [HW-1:0] hcnt_q, x;
   logic [VW-1:0] vcnt_q;
   logic i480_q, field_q, blur_q, ndsync_q, fs_q, field_o_q;
   pat_e pat_q;
   logic [CW-1:0] d_q, word_d;
   logic h_end, v_end, frame_end, hs, clamp, vs, active, y0;
   rgb_t rgb;

   assign h_end = hcnt_q == HW'(H_TOTAL - 1);
   // field_q=1 is the odd 480i field; the even field is one line short
   assign v_end = vcnt_q == ((i480_q && !field_q) ? VW'(V_TOTAL - 2) : VW'(V_TOTAL - 1));
   assign frame_end = wcnt_q == W_B && h_end && v_end;
   assign hs = hcnt_q < HW'(H_SYNC);
   assign clamp = hcnt_q >= HW'(H_SYNC) && hcnt_q < HW'(H_SYNC + CLAMP_W);
   // odd field: vsync runs from mid-line 0 to mid-line V_SYNC
   assign vs = (i480_q && field_q)
      ? (vcnt_q == '0 ? hcnt_q >= HW'(H_TOTAL / 2)
                      : vcnt_q < VW'(V_SYNC) || (vcnt_q == VW'(V_SYNC) && hcnt_q < HW'(H_TOTAL / 2)))
      : vcnt_q < VW'(V_SYNC);
   assign active = hcnt_q >= HW'(H_ACT_START) && hcnt_q < HW'(H_ACT_START + H_ACT)
                && vcnt_q >= VW'(V_ACT_START) && vcnt_q < VW'(V_ACT_START + V_ACT);
   assign x = hcnt_q - HW'(H_ACT_START);
   assign y0 = vcnt_q[0] ^ V_ACT_START[0];

   n64_vbus_gen_pattern #(.H_ACT(H_ACT)) u_pattern (
      .x_i(x),
      .y0_i(y0),
      .active_i(active),
      .pattern_i(pat_q),
      .blur_i(blur_q),
      .rgb_o(rgb)
   );

   assign word_d = wcnt_q == W_SYNC ? sync_word(!vs, !clamp, !hs, vs ? hs : !hs)
                 : wcnt_q == W_R ? rgb.r
                 : wcnt_q == W_G ? rgb.g : rgb.b;

   always_ff @(posedge VCLK) begin
      if (RST) begin
         wcnt_q <= '0;
         hcnt_q <= '0;
         vcnt_q <= '0;
         i480_q <= 1'b0;
         field_q <= 1'b0;
         blur_q <= 1'b0;
         pat_q <= PAT_BARS;
         ndsync_q <= 1'b1;
         d_q <= '0;
         fs_q <= 1'b0;
         field_o_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_q + 2'd1;
         if (wcnt_q == W_B) hcnt_q <= h_end ? '0 : hcnt_q + HW'(1);
         if (wcnt_q == W_B && h_end) vcnt_q <= v_end ? '0 : vcnt_q + VW'(1);
         if (frame_end) begin
            i480_q <= bus.n64_480i_i;
            field_q <= bus.n64_480i_i && !field_q;
            pat_q <= pat_e'(bus.pattern_i);
            blur_q <= bus.blur_i;
         end
         ndsync_q <= wcnt_q != W_SYNC;
         d_q <= word_d;
         fs_q <= wcnt_q == W_SYNC && hcnt_q == '0 && vcnt_q == '0;
         field_o_q <= field_q;
      end
   end

   assign bus.nDSYNC = ndsync_q;
   assign bus.D_o = d_q;
   assign bus.frame_start_o = fs_q;
   assign bus.field_o = field_o_q;
endmodule
